dec_lut_encoder24bits_clk: RTL and testbench

Sequential encoder that produces the 39-bit codeword W consumed by the DEC_LUT 24-bit decoder from a 24-bit value N. It uses the mapping W = N × K, where K is a fixed 15-bit parameter. The product is built by a radix-2 shift-add datapath over 24 cycles behind a start/done handshake. It sits on the transmit side of the decoder path and also generates golden codewords for decoder regression.

---
 rtl/dec_lut_encoder24bits_clk.sv | 109 ++++++++++
 tb/tb_dec_lut_encoder24bits_clk.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dec_lut_encoder24bits_clk.sv
// Sequential shift-add encoder for the DEC_LUT 24-bit decoder path.
// Computes W = N * K, one multiplicand bit per clock, behind a start/done handshake.
//
// Handshake: a request is accepted on a rising clk edge where start=1 and the
// block is idle (busy=0). N is captured on that edge only. Requests while busy
// are dropped. Exactly N_BITS edges later W is updated and done pulses for one
// cycle. W holds its value between completions.
module dec_lut_encoder24bits_clk #(
   parameter int unsigned        N_BITS = 24,
   parameter int unsigned        K_BITS = 15,
   parameter int unsigned        W_BITS = 39,
   parameter logic [K_BITS-1:0]  K      = 15'd32767
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [N_BITS-1:0] N,
   output logic              busy,
   output logic              done,
   output logic [W_BITS-1:0] W
);

   localparam int unsigned CNT_W = $clog2(N_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BITS - 1);

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [N_BITS-1:0] mcand_q, mcand_d;
   logic [W_BITS-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [W_BITS-1:0] w_q, w_d;

   // K widened to the accumulator width so the shifted addend never truncates.
   logic [W_BITS-1:0] k_ext;
   logic [W_BITS-1:0] addend;
   logic [W_BITS-1:0] acc_sum;

   assign k_ext   = W_BITS'(K);
   assign addend  = mcand_q[0] ? (k_ext << cnt_q) : '0;
   assign acc_sum = acc_q + addend;

   // Next-state and datapath control; done is a pulse, so it defaults low every cycle.
   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      w_d     = w_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d = N;
               acc_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = MUL;
            end
         end
         MUL: begin
            acc_d   = acc_sum;
            mcand_d = mcand_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               w_d     = acc_sum;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset clears everything including W.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         mcand_q <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         w_q     <= '0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         w_q     <= w_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign W    = w_q;

endmodule

// File: tb/tb_dec_lut_encoder24bits_clk.sv
// Directed bench for dec_lut_encoder24bits_clk: vector table plus hand-written
// sequences for reset, ignored start, mid-run reset and back-to-back requests.
module tb_dec_lut_encoder24bits_clk;

  logic        clk;
  logic        rst;
  logic        start;
  logic [23:0] n_in;
  logic        busy;
  logic        done;
  logic [38:0] w_out;

  int tests;
  int fails;
  logic [38:0] last_w;

  typedef struct {
    logic [23:0] n;
    logic [38:0] w;
  } vec_t;

  vec_t vecs[4];

  dec_lut_encoder24bits_clk dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .N     (n_in),
    .busy  (busy),
    .done  (done),
    .W     (w_out)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One isolated request: one-cycle start, done expected exactly 24 edges after accept.
  task automatic run_one(input logic [23:0] n, input logic [38:0] exp_w, input string name);
    int   first;
    logic busy_ok;
    logic hold_ok;
    first   = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    @(negedge clk);
    start = 1'b1;
    n_in  = n;
    @(posedge clk);   // E0
    #1;
    start = 1'b0;
    n_in  = ~n;       // must not matter during MUL
    check({name, " busy after accept"}, busy, 1'b1);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        first = k;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (w_out !== last_w) hold_ok = 1'b0;
    end
    check({name, " done edge"}, first, 24);
    check({name, " busy held"}, busy_ok, 1'b1);
    check({name, " W held during run"}, hold_ok, 1'b1);
    check({name, " W"}, w_out, exp_w);
    check({name, " busy at done"}, busy, 1'b0);
    last_w = exp_w;
    @(posedge clk);
    #1;
    check({name, " done one cycle"}, done, 1'b0);
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    last_w = '0;
    rst    = 1'b0;
    start  = 1'b0;
    n_in   = '0;

    vecs[0] = '{n: 24'd16777215, w: 39'd549739003905};
    vecs[1] = '{n: 24'd0,        w: 39'd0};
    vecs[2] = '{n: 24'd1,        w: 39'd32767};
    vecs[3] = '{n: 24'd12345678, w: 39'd404530831026};

    // Reset asserted mid-cycle for 15 ns: outputs clear immediately.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset W", w_out, 39'd0);
    #14 rst = 1'b0;
    begin
      logic idle_ok;
      idle_ok = 1'b1;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk);
        #1;
        if (busy !== 1'b0 || done !== 1'b0 || w_out !== 39'd0) idle_ok = 1'b0;
      end
      check("idle after reset", idle_ok, 1'b1);
    end

    // Table of independent requests; W must hold 10 cycles afterwards.
    for (int i = 0; i < 4; i++) begin
      run_one(vecs[i].n, vecs[i].w, $sformatf("vec%0d", i));
      repeat (10) @(posedge clk);
      #1;
      check($sformatf("vec%0d W hold", i), w_out, vecs[i].w);
    end

    // Ignored start: N=1 accepted, start pulsed with N=5 at E5.
    begin
      int first;
      int pulses;
      first  = 0;
      pulses = 0;
      @(negedge clk);
      start = 1'b1;
      n_in  = 24'd1;
      @(posedge clk);  // E0
      #1 start = 1'b0;
      for (int k = 1; k <= 35; k++) begin
        if (k == 5) begin
          @(negedge clk);
          start = 1'b1;
          n_in  = 24'd5;
        end
        @(posedge clk);
        #1;
        if (k == 5) start = 1'b0;
        if (done) begin
          pulses++;
          if (first == 0) first = k;
          if (k == 24) check("ignored start W", w_out, 39'd32767);
        end
      end
      check("ignored start done edge", first, 24);
      check("ignored start pulses", pulses, 1);
      check("ignored start idle", busy, 1'b0);
      last_w = 39'd32767;
    end

    // Reset mid-operation at E10: no done, then a clean request.
    begin
      int pulses;
      pulses = 0;
      @(negedge clk);
      start = 1'b1;
      n_in  = 24'd16777215;
      @(posedge clk);  // E0
      #1 start = 1'b0;
      repeat (10) @(posedge clk);  // E10
      #1 rst = 1'b1;
      #1;
      check("midrun reset busy", busy, 1'b0);
      check("midrun reset W", w_out, 39'd0);
      #2 rst = 1'b0;
      for (int k = 0; k < 30; k++) begin
        @(posedge clk);
        #1;
        if (done) pulses++;
      end
      check("midrun reset no done", pulses, 0);
      last_w = 39'd0;
      run_one(24'd2, 39'd65534, "after reset");
    end

    // Back-to-back: start held, N=3 then N=4.
    begin
      int d1;
      int d2;
      d1 = 0;
      d2 = 0;
      @(negedge clk);
      start = 1'b1;
      n_in  = 24'd3;
      @(posedge clk);  // E0
      #1 n_in = 24'd4;
      for (int k = 1; k <= 60; k++) begin
        @(posedge clk);
        #1;
        if (k == 25) begin
          check("b2b second accept busy", busy, 1'b1);
          check("b2b done cleared", done, 1'b0);
          start = 1'b0;
        end
        if (done) begin
          if (d1 == 0) begin
            d1 = k;
            check("b2b first W", w_out, 39'd98301);
          end else if (d2 == 0) begin
            d2 = k;
            check("b2b second W", w_out, 39'd131068);
          end
        end
      end
      check("b2b first done edge", d1, 24);
      check("b2b second done edge", d2, 49);
      check("b2b final W", w_out, 39'd131068);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
